// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer block.
// Holds the geometry constants, the plane and FSM encodings, the word-count
// helpers, and the function that maps a plane to its base offset, stride and size.
// Optional feature macro used by the design: FB_PAD_EN (right-edge padding reads).
package fb_pkg;

  localparam int MEM_WIDTH  = 64;
  localparam int MAX_WIDTH  = 352;
  localparam int MAX_HEIGHT = 288;
  localparam int DIM_BITS   = 12;

  function automatic int calc_bpw(input int mem_width);
    return mem_width / 8;
  endfunction

  function automatic int calc_depth(input int mem_width, input int w, input int h);
    return (w * h * 3 / 2) / calc_bpw(mem_width);
  endfunction

  localparam int BPW       = calc_bpw(MEM_WIDTH);
  localparam int BPW_LG    = $clog2(BPW);
  localparam int DEPTH     = calc_depth(MEM_WIDTH, MAX_WIDTH, MAX_HEIGHT);
  localparam int ADDR_BITS = $clog2(DEPTH);
  // Byte offsets are computed at this width so that no intermediate term wraps.
  localparam int AW        = 2 * DIM_BITS + 1;

  typedef enum logic [1:0] {
    PLANE_Y   = 2'd0,
    PLANE_U   = 2'd1,
    PLANE_V   = 2'd2,
    PLANE_BAD = 2'd3
  } plane_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  typedef struct packed {
    logic [AW-1:0] base;    // plane start, bytes
    logic [AW-1:0] stride;  // plane stride, bytes
    logic [AW-1:0] pw;      // plane width, pixels
    logic [AW-1:0] ph;      // plane height, rows
  } plane_geom_t;

  function automatic plane_geom_t plane_geom(input plane_e p,
                                             input logic [DIM_BITS-1:0] s,
                                             input logic [DIM_BITS-1:0] w,
                                             input logic [DIM_BITS-1:0] h);
    plane_geom_t   g;
    logic [AW-1:0] sf, wf, hf, luma;
    sf   = AW'(s);
    wf   = AW'(w);
    hf   = AW'(h);
    luma = sf * hf;
    case (p)
      PLANE_U: begin
        g.base = luma;
        g.stride = sf >> 1; g.pw = wf >> 1; g.ph = hf >> 1;
      end
      PLANE_V: begin
        g.base = luma + (sf >> 1) * (hf >> 1);
        g.stride = sf >> 1; g.pw = wf >> 1; g.ph = hf >> 1;
      end
      default: begin
        g.base = '0;
        g.stride = sf; g.pw = wf; g.ph = hf;
      end
    endcase
    return g;
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Block-row word-address generator.
// On load_i it validates the request, clamps the start row into the plane and
// registers the word address of row 0; each step_i advances one row, holding on
// the last plane row (vertical clamp).
// Ports: clk_i/rst_i; load_i (accept), step_i (row issued); plane_i, x_i, y_i
// request; stride_i/width_i/height_i frame config; legal_o (combinational
// verdict for the current request); addr_o current row word address; pad_o
// block is a right-edge padding block.
// Macro FB_PAD_EN: accept x beyond the plane width and serve the rightmost word.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [1:0]           plane_i,
  input  logic [DIM_BITS-1:0]  x_i,
  input  logic [DIM_BITS-1:0]  y_i,
  input  logic [DIM_BITS-1:0]  stride_i,
  input  logic [DIM_BITS-1:0]  width_i,
  input  logic [DIM_BITS-1:0]  height_i,
  output logic                 legal_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 pad_o
);

  plane_geom_t   g;
  logic [AW-1:0] x_f, y_f, x_eff, y_eff, start_b;
  logic          aligned, x_over, y_over, plane_ok;
  logic [AW-1:0] word_q, y_q, ph_q, stride_w_q;
  logic          unused_hi;

  assign g        = plane_geom(plane_e'(plane_i), stride_i, width_i, height_i);
  assign x_f      = AW'(x_i);
  assign y_f      = AW'(y_i);
  assign aligned  = (x_i[BPW_LG-1:0] == '0);
  assign plane_ok = (plane_e'(plane_i) != PLANE_BAD);
  assign x_over   = (x_f >= g.ph - g.ph + g.pw);
  assign y_over   = (y_f >= g.ph);
  assign y_eff    = y_over ? g.ph - AW'(1) : y_f;

`ifdef FB_PAD_EN
  logic pad_q;
  // Past the right edge the block collapses onto the last word of the row.
  assign x_eff   = x_over ? g.pw - AW'(BPW) : x_f;
  assign legal_o = plane_ok && aligned && (y_f < g.ph + AW'(BPW));
  assign pad_o   = pad_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       pad_q <= 1'b0;
    else if (load_i) pad_q <= x_over;
  end
`else
  assign x_eff   = x_f;
  assign legal_o = plane_ok && aligned && !x_over && !y_over;
  assign pad_o   = 1'b0;
`endif

  assign start_b = g.base + y_eff * g.stride + x_eff;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q     <= '0;
      y_q        <= '0;
      ph_q       <= '0;
      stride_w_q <= '0;
    end else if (load_i) begin
      word_q     <= start_b >> BPW_LG;
      y_q        <= y_eff;
      ph_q       <= g.ph;
      stride_w_q <= g.stride >> BPW_LG;
    end else if (step_i && (y_q + AW'(1) < ph_q)) begin
      word_q <= word_q + stride_w_q;
      y_q    <= y_q + AW'(1);
    end
  end

  // The RAM index is the low bits of the full-width word address.
  assign addr_o    = word_q[ADDR_BITS-1:0];
  assign unused_hi = ^word_q[AW-1:ADDR_BITS];

endmodule

// File: rtl/frame_buffer_blk.sv
// Planar YUV 4:2:0 frame buffer: raster word load, then BPW x BPW block reads.
// Ports: clk, reset (async, active high); setup_frame + stride_in/width_in/
// height_in configure and restart the load; fb_write/fb_data load words while
// fb_ready; frame_done once the whole frame is stored; rd_req/rd_plane/rd_x/
// rd_y request a block while rd_ready; rd_err flags a rejected request;
// blk_valid/blk_data/blk_last stream the block rows.
// Macro FB_PAD_EN: right-edge padding reads (see fb_addr_gen).
//
// state    | meaning
// ST_IDLE  | unconfigured, nothing accepted
// ST_LOAD  | accepting raster words
// ST_READY | frame stored, accepting block requests
// ST_READ  | streaming one block
module frame_buffer_blk
  import fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 setup_frame,
  input  logic [DIM_BITS-1:0]  stride_in,
  input  logic [DIM_BITS-1:0]  width_in,
  input  logic [DIM_BITS-1:0]  height_in,
  input  logic                 fb_write,
  input  logic [MEM_WIDTH-1:0] fb_data,
  output logic                 fb_ready,
  output logic                 frame_done,
  input  logic                 rd_req,
  input  logic [1:0]           rd_plane,
  input  logic [DIM_BITS-1:0]  rd_x,
  input  logic [DIM_BITS-1:0]  rd_y,
  output logic                 rd_ready,
  output logic                 rd_err,
  output logic                 blk_valid,
  output logic [MEM_WIDTH-1:0] blk_data,
  output logic                 blk_last
);

  state_e                state_q, state_d;
  logic [DIM_BITS-1:0]   stride_q, width_q, height_q;
  logic [AW-1:0]         wr_ptr_q, luma_px, total_w;
  logic                  frame_done_q, vld_q, last_q, pad_dly_q, err_q;
  logic [BPW_LG:0]       cnt_q;
  logic [MEM_WIDTH-1:0]  rdata_q;
  logic [MEM_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_BITS-1:0]  rd_addr, ram_addr;
  logic                  legal, pad, accept, reject, wr_en, wr_last, issue;

  assign luma_px = AW'(stride_q) * AW'(height_q);
  assign total_w = (luma_px + (luma_px >> 1)) >> BPW_LG;

  assign accept  = (state_q == ST_READY) && rd_req && !setup_frame && legal;
  assign reject  = (state_q == ST_READY) && rd_req && !setup_frame && !legal;
  assign wr_en   = (state_q == ST_LOAD) && fb_write && !setup_frame;
  assign wr_last = wr_en && (wr_ptr_q == total_w - AW'(1));
  // One row address per cycle for BPW cycles; the top counter bit marks done.
  assign issue   = (state_q == ST_READ) && !cnt_q[BPW_LG];

  fb_addr_gen u_addr_gen (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (accept),
    .step_i   (issue),
    .plane_i  (rd_plane),
    .x_i      (rd_x),
    .y_i      (rd_y),
    .stride_i (stride_q),
    .width_i  (width_q),
    .height_i (height_q),
    .legal_o  (legal),
    .addr_o   (rd_addr),
    .pad_o    (pad)
  );

  always_comb begin
    state_d = state_q;
    if (setup_frame) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  if (wr_last) state_d = ST_READY;
        ST_READY: if (accept)  state_d = ST_READ;
        ST_READ:  if (last_q)  state_d = ST_READY;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      stride_q     <= '0;
      width_q      <= '0;
      height_q     <= '0;
      wr_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      vld_q        <= 1'b0;
      last_q       <= 1'b0;
      pad_dly_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= reject;
      vld_q     <= issue && !setup_frame;
      last_q    <= issue && !setup_frame && (cnt_q == (BPW_LG+1)'(BPW-1));
      pad_dly_q <= pad;
      if (setup_frame) begin
        stride_q     <= stride_in;
        width_q      <= width_in;
        height_q     <= height_in;
        wr_ptr_q     <= '0;
        frame_done_q <= 1'b0;
        cnt_q        <= '0;
      end else begin
        if (wr_en)   wr_ptr_q     <= wr_ptr_q + AW'(1);
        if (wr_last) frame_done_q <= 1'b1;
        if (accept)     cnt_q <= '0;
        else if (issue) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Single-port RAM: writes only happen in LOAD, reads only in READ.
  assign ram_addr = wr_en ? wr_ptr_q[ADDR_BITS-1:0] : rd_addr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[ram_addr] <= fb_data;
    rdata_q <= mem[ram_addr];
  end

  assign fb_ready   = (state_q == ST_LOAD);
  assign rd_ready   = (state_q == ST_READY);
  assign frame_done = frame_done_q;
  assign rd_err     = err_q;
  assign blk_valid  = vld_q;
  assign blk_last   = last_q;
  // Padding blocks replicate the rightmost pixel (top byte) across the row.
  assign blk_data   = !vld_q    ? '0 :
                      pad_dly_q ? {BPW{rdata_q[MEM_WIDTH-1 -: 8]}} : rdata_q;

endmodule

// File: tb/tb_frame_buffer_blk.sv
module tb_frame_buffer_blk;

  logic        clk = 1'b0;
  logic        reset;
  logic        setup_frame;
  logic [11:0] stride_in, width_in, height_in;
  logic        fb_write;
  logic [63:0] fb_data;
  logic        fb_ready, frame_done;
  logic        rd_req;
  logic [1:0]  rd_plane;
  logic [11:0] rd_x, rd_y;
  logic        rd_ready, rd_err, blk_valid, blk_last;
  logic [63:0] blk_data;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] salt;

  frame_buffer_blk dut (
    .clk(clk), .reset(reset), .setup_frame(setup_frame),
    .stride_in(stride_in), .width_in(width_in), .height_in(height_in),
    .fb_write(fb_write), .fb_data(fb_data), .fb_ready(fb_ready),
    .frame_done(frame_done), .rd_req(rd_req), .rd_plane(rd_plane),
    .rd_x(rd_x), .rd_y(rd_y), .rd_ready(rd_ready), .rd_err(rd_err),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  plane;
    logic [11:0] x, y;
    logic        exp_err;
    int unsigned addr0, step, clamp_row;
  } vec_t;

  vec_t vecs[8];

  // Word i of the frame: distinct top byte (used by padding) and counting low word.
  function automatic logic [63:0] pat(input int unsigned i, input logic [7:0] s);
    logic [31:0] lo;
    lo = i;
    return {8'(i * 7 + 3) ^ s, 24'h0, lo ^ {4{s}}};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Starts and ends at a falling edge.
  task automatic run_read(input string nm, input logic [1:0] p, input logic [11:0] x,
                          input logic [11:0] y, input logic exp_err, input int unsigned a0,
                          input int unsigned st, input int unsigned cr, input logic padded);
    logic [63:0] w, e;
    int unsigned a;
    check({nm, " rd_ready"}, 64'(rd_ready), 64'd1);
    rd_req = 1'b1; rd_plane = p; rd_x = x; rd_y = y;
    @(negedge clk);
    rd_req = 1'b0;
    check({nm, " rd_err"}, 64'(rd_err), 64'(exp_err));
    check({nm, " early valid"}, 64'(blk_valid), 64'd0);
    if (exp_err) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check({nm, " err no valid"}, 64'(blk_valid), 64'd0);
      end
      check({nm, " err pulse end"}, 64'(rd_err), 64'd0);
    end else begin
      for (int r = 0; r < 8; r++) begin
        @(negedge clk);
        a = a0 + st * ((r < int'(cr)) ? r : cr);
        w = pat(a, salt);
        e = padded ? {8{w[63:56]}} : w;
        check($sformatf("%s row%0d valid", nm, r), 64'(blk_valid), 64'd1);
        check($sformatf("%s row%0d data", nm, r), blk_data, e);
        check($sformatf("%s row%0d last", nm, r), 64'(blk_last), 64'(r == 7));
      end
      @(negedge clk);
      check({nm, " valid after"}, 64'(blk_valid), 64'd0);
    end
  endtask

  task automatic load_frame();
    setup_frame = 1'b1;
    fb_write = 1'b1;        // must be ignored in the setup cycle
    fb_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    setup_frame = 1'b0;
    fb_write = 1'b0;
    check("load fb_ready", 64'(fb_ready), 64'd1);
    check("load frame_done", 64'(frame_done), 64'd0);
    for (int i = 0; i < 19008; i++) begin
      fb_write = 1'b1;
      fb_data = pat(i, salt);
      if (i == 19007) begin
        check("pre-last frame_done", 64'(frame_done), 64'd0);
        check("pre-last fb_ready", 64'(fb_ready), 64'd1);
      end
      @(negedge clk);
    end
    check("post-last fb_ready", 64'(fb_ready), 64'd0);
    check("post-last frame_done", 64'(frame_done), 64'd1);
    check("post-last rd_ready", 64'(rd_ready), 64'd1);
    fb_data = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) @(negedge clk);
    fb_write = 1'b0;
    check("extra write frame_done", 64'(frame_done), 64'd1);
  endtask

  task automatic run_table();
    foreach (vecs[i])
      run_read(vecs[i].name, vecs[i].plane, vecs[i].x, vecs[i].y, vecs[i].exp_err,
               vecs[i].addr0, vecs[i].step, vecs[i].clamp_row, 1'b0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; setup_frame = 1'b0; fb_write = 1'b0; fb_data = '0;
    stride_in = 12'd352; width_in = 12'd352; height_in = 12'd288;
    rd_req = 1'b0; rd_plane = 2'd0; rd_x = '0; rd_y = '0; salt = 8'h00;

    vecs[0] = '{"Y16_8",   2'd0, 12'd16,  12'd8,   1'b0, 354,   44, 7};
    vecs[1] = '{"U8_0",    2'd1, 12'd8,   12'd0,   1'b0, 12673, 22, 7};
    vecs[2] = '{"V0_0",    2'd2, 12'd0,   12'd0,   1'b0, 15840, 22, 7};
    vecs[3] = '{"Y0_284",  2'd0, 12'd0,   12'd284, 1'b0, 12496, 44, 3};
    vecs[4] = '{"U168_136",2'd1, 12'd168, 12'd136, 1'b0, 15685, 22, 7};
    vecs[5] = '{"V0_143",  2'd2, 12'd0,   12'd143, 1'b0, 18986, 22, 0};
    vecs[6] = '{"plane3",  2'd3, 12'd0,   12'd0,   1'b1, 0,     0,  0};
    vecs[7] = '{"misalign",2'd0, 12'd4,   12'd0,   1'b1, 0,     0,  0};

    repeat (2) @(negedge clk);
    check("rst fb_ready", 64'(fb_ready), 64'd0);
    check("rst frame_done", 64'(frame_done), 64'd0);
    check("rst rd_ready", 64'(rd_ready), 64'd0);
    check("rst rd_err", 64'(rd_err), 64'd0);
    check("rst blk_valid", 64'(blk_valid), 64'd0);
    check("rst blk_data", blk_data, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    rd_req = 1'b1; rd_plane = 2'd3;
    @(negedge clk);
    rd_req = 1'b0;
    check("idle rd_req rd_err", 64'(rd_err), 64'd0);
    check("idle rd_ready", 64'(rd_ready), 64'd0);

    load_frame();
    run_table();
    run_read("Y0_0", 2'd0, 12'd0, 12'd0, 1'b0, 0, 44, 7, 1'b0);
    run_read("Yy300", 2'd0, 12'd0, 12'd300, 1'b1, 0, 0, 0, 1'b0);
`ifdef FB_PAD_EN
    run_read("Ypad352", 2'd0, 12'd352, 12'd0, 1'b0, 43, 44, 7, 1'b1);
    run_read("Upad176", 2'd1, 12'd176, 12'd0, 1'b0, 12693, 22, 7, 1'b1);
`else
    run_read("Yx352", 2'd0, 12'd352, 12'd0, 1'b1, 0, 0, 0, 1'b0);
    run_read("Ux176", 2'd1, 12'd176, 12'd0, 1'b1, 0, 0, 0, 1'b0);
    run_read("Uy144", 2'd1, 12'd0, 12'd144, 1'b1, 0, 0, 0, 1'b0);
`endif

    // setup_frame in the middle of a block
    rd_req = 1'b1; rd_plane = 2'd0; rd_x = 12'd0; rd_y = 12'd0;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check("abort pre valid", 64'(blk_valid), 64'd1);
    setup_frame = 1'b1;
    @(negedge clk);
    setup_frame = 1'b0;
    check("abort blk_valid", 64'(blk_valid), 64'd0);
    check("abort frame_done", 64'(frame_done), 64'd0);
    check("abort fb_ready", 64'(fb_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (blk_valid) seen++;
    end
    check("abort no more rows", 64'(seen), 64'd0);

    // reset in the middle of a load
    for (int i = 0; i < 100; i++) begin
      fb_write = 1'b1; fb_data = 64'hFFFF_0000_FFFF_0000;
      @(negedge clk);
    end
    fb_write = 1'b0;
    reset = 1'b1;
    #1;
    check("midload rst fb_ready", 64'(fb_ready), 64'd0);
    check("midload rst frame_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post rst idle", 64'(fb_ready), 64'd0);

    salt = 8'h5A;
    load_frame();
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_buffer_blk.md
Name: frame_buffer_blk

Overview:
Second-generation frame buffer for the encoder front end. It accepts one planar YUV 4:2:0 frame as raster-order memory words, then serves square block reads from any plane. Each block row is one aligned memory word. It sits between the raw-frame loader and the motion-estimation/transform fetch logic, and replaces the luma-only, write-only buffer.

Parameters:
MEM_WIDTH, 64, memory word width in bits; BPW = MEM_WIDTH/8 pixels per word; blocks are BPW x BPW pixels
MAX_WIDTH, 352, largest supported luma width/stride in pixels
MAX_HEIGHT, 288, largest supported luma height
DIM_BITS, 12, width of stride/width/height/coordinate fields

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
setup_frame  in  1  latch stride_in/width_in/height_in; restart load
stride_in  in  DIM_BITS  luma stride in pixels (multiple of 2*BPW)
width_in  in  DIM_BITS  luma width in pixels (multiple of 2*BPW)
height_in  in  DIM_BITS  luma height in pixels (even)
fb_write  in  1  write strobe for fb_data
fb_data  in  MEM_WIDTH  next raster word; byte 0 = leftmost pixel
fb_ready  out  1  buffer is accepting writes
frame_done  out  1  full frame stored; reads allowed
rd_req  in  1  block read request
rd_plane  in  2  0=Y, 1=U, 2=V; 3 is illegal
rd_x  in  DIM_BITS  block left pixel column in the plane (multiple of BPW)
rd_y  in  DIM_BITS  block top pixel row in the plane
rd_ready  out  1  request will be accepted this cycle
rd_err  out  1  one-cycle pulse: request rejected
blk_valid  out  1  blk_data holds a block row
blk_data  out  MEM_WIDTH  block row pixels
blk_last  out  1  marks the final row of the block

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; write pointer 0; config registers 0.
- Internal single-port synchronous RAM, DEPTH = MAX_WIDTH*MAX_HEIGHT*3/2/BPW words (19008 at defaults).
- Plane layout in bytes:
  - Y base 0, stride S.
  - U base S*H, stride S/2.
  - V base S*H + (S/2)*(H/2).
  - Word address = (base + y*plane_stride + x)/BPW.
- Frame size: TOTAL = S*H*3/2/BPW words.
- FSM IDLE -> LOAD -> READY <-> READ.
  - IDLE: fb_ready=0, rd_ready=0.
  - setup_frame (any state) has top priority and goes to LOAD next cycle. It latches the config, clears the write pointer and frame_done, and aborts any block in flight; no further blk_valid follows.
  - LOAD: fb_ready=1. Each cycle with fb_write=1 stores fb_data at the pointer, and the pointer increments. When the word numbered TOTAL-1 is written, the FSM goes to READY next cycle and frame_done=1.
  - fb_write is ignored outside LOAD, and also in the cycle setup_frame is high.
  - READY: rd_ready=1. rd_req with a legal request moves to READ.
  - Illegal request (rd_plane=3, x >= plane width, y >= plane height, or rd_x not a multiple of BPW): rd_err=1 next cycle, FSM stays in READY.
  - READ: rd_ready=0. Cycle 1 registers the base address. blk_valid rises 2 cycles after acceptance and holds for BPW consecutive cycles, with no backpressure. blk_last is high on row BPW-1. The FSM returns to READY the cycle after blk_last, so back-to-back requests have a 1-cycle bubble.
  - Rows with y+row >= plane height return the last valid row (vertical clamp), always.
- Address arithmetic is done at full width (DIM_BITS*2+1 bits) with no wrap; the RAM address is truncated only after division.
- rd_req while not in READY: ignored, no rd_err.

Optional Feature:
FB_PAD_EN.
- Defined: a block with x >= plane width and a legal plane/y/alignment is accepted, not rejected. Each row returns the rightmost pixel of the clamped row, replicated BPW times (codec edge padding). rd_err is raised only for rd_plane=3, misalignment, or y >= plane height + BPW.
- Undefined: such requests give rd_err.

Decomposition:
- Package fb_pkg: plane enumeration (PLANE_Y/U/V), FSM state typedef, BPW/DEPTH derivation functions, plane base/stride function.
- One sub-module fb_addr_gen: registered plane/row to word-address generator, including the clamp and pad-select logic.
- The RAM is an inferred array in the top module.

Test Plan:
1. CIF setup (352/352/288), 19008 writes of counting words -> fb_ready falls and frame_done=1 on the cycle after word 19007; extra fb_write has no effect.
2. Y block rd_x=16, rd_y=8 -> blk_valid 2 cycles after accept; rows = words 354, 398, ... (step 44); blk_last on the 8th row.
3. U block (8,0) -> first word 12673. V block (0,0) -> first word 15840. Each returns 8 rows at step 22.
4. Y block (0,284) -> rows 4..7 repeat word (287*352)/8 = 12628.
5. rd_x=352 on Y: without FB_PAD_EN -> rd_err pulse and no blk_valid. With FB_PAD_EN -> 8 rows each equal to byte 7 of word 43+44*row replicated.
6. setup_frame mid-READ and reset mid-LOAD -> blk_valid stops next cycle and frame_done=0; the reload completes correctly.
